ddr_rd_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single DDR read-command/read-data port between NUM_REQ burst buffer controllers (FIR tap vout buffer, laser/pre-buffer readers, etc.).
- Each requester presents a level request with its own length and address. The arbiter issues one burst at a time to the DDR read engine and routes the returned beats and the finish pulse back to the granted requester only.
- Sits between the buffer controllers and the DDR AXI read master, in the ddr_clk_i domain.

---
 rtl/ddr_arb_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/ddr_rd_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ddr_rd_port_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR port arbiters (read and write side).
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int unsigned LEN_W           = 8;
    localparam int unsigned BEAT_CNT_W      = 9;
    localparam int unsigned WDOG_CNT_W      = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 4096;

    // Pointer width for an n-way arbiter; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap-around.
module rr_priority_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [PTR_W:0] pos;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            if (!valid && req[pos[PTR_W-1:0]]) begin
                grant[pos[PTR_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_rd_port_arbiter.sv
// Round-robin arbiter sharing one DDR read port between NUM_REQ burst readers.
// Optional burst watchdog enabled by defining DDR_RD_ARB_WATCHDOG_EN.
module ddr_rd_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDR_WIDTH    = 30,
    parameter int unsigned MEM_DATA_BITS = 256,
    parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic                          ddr_clk_i,
    input  logic                          ddr_rst_n_i,
    input  logic [NUM_REQ-1:0]            s_req_i,
    input  logic [NUM_REQ*LEN_W-1:0]      s_len_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr_i,
    output logic [NUM_REQ-1:0]            s_data_valid_o,
    output logic [MEM_DATA_BITS-1:0]      s_data_o,
    output logic [NUM_REQ-1:0]            s_finish_o,
    output logic                          m_req_o,
    output logic [LEN_W-1:0]              m_len_o,
    output logic [ADDR_WIDTH-1:0]         m_addr_o,
    input  logic                          m_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0]      m_data_i,
    input  logic                          m_finish_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          len_err_o
`ifdef DDR_RD_ARB_WATCHDOG_EN
    ,
    output logic                          wdog_err_o
`endif
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    arb_state_e              state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        g_idx;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [NUM_REQ-1:0]      pick_grant;
    logic                    pick_valid;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic                    beat_fwd;
    logic [LEN_W-1:0]        len_arr  [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign len_arr[k]  = s_len_i[k*LEN_W +: LEN_W];
        assign addr_arr[k] = s_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (s_req_i),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Index of the one-hot pick, used to select the winner's length/address.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign next_ptr = (g_idx == PTR_W'(NUM_REQ-1)) ? '0 : g_idx + PTR_W'(1);
    assign beat_fwd = m_data_valid_i && ((state == ISSUE) || (state == XFER));

`ifdef DDR_RD_ARB_WATCHDOG_EN
    logic [WDOG_CNT_W-1:0] wdog_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            g_idx          <= '0;
            beat_cnt       <= '0;
            grant_o        <= '0;
            m_req_o        <= 1'b0;
            m_len_o        <= '0;
            m_addr_o       <= '0;
            s_data_valid_o <= '0;
            s_data_o       <= '0;
            s_finish_o     <= '0;
            busy_o         <= 1'b0;
            len_err_o      <= 1'b0;
`ifdef DDR_RD_ARB_WATCHDOG_EN
            wdog_cnt       <= '0;
            wdog_err_o     <= 1'b0;
`endif
        end else begin
            s_data_valid_o <= '0;
            s_finish_o     <= '0;

            // Beats are only forwarded while a burst is owned; strays in IDLE/DONE are dropped.
            if (beat_fwd) begin
                s_data_valid_o <= grant_o;
                s_data_o       <= m_data_i;
                beat_cnt       <= beat_cnt + BEAT_CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_o  <= pick_grant;
                        g_idx    <= pick_idx;
                        m_len_o  <= len_arr[pick_idx];
                        m_addr_o <= addr_arr[pick_idx];
                        beat_cnt <= '0;
                        m_req_o  <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= ISSUE;
`ifdef DDR_RD_ARB_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                    end
                end
                ISSUE: begin
                    // A finish while still issuing (zero-beat burst) completes directly.
                    if (m_finish_i) begin
                        m_req_o <= 1'b0;
                        state   <= DONE;
                    end else if (m_data_valid_i) begin
                        m_req_o <= 1'b0;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (m_finish_i) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    s_finish_o <= grant_o;
                    if (beat_cnt != BEAT_CNT_W'(m_len_o)) begin
                        len_err_o <= 1'b1;
                    end
                    rr_ptr  <= next_ptr;
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef DDR_RD_ARB_WATCHDOG_EN
            // Abandon a burst whose finish never arrives.
            if ((state == ISSUE) || (state == XFER)) begin
                wdog_cnt <= wdog_cnt + WDOG_CNT_W'(1);
                if (wdog_cnt == WDOG_CNT_W'(TIMEOUT_CYC - 1)) begin
                    m_req_o    <= 1'b0;
                    len_err_o  <= 1'b1;
                    wdog_err_o <= 1'b1;
                    state      <= DONE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// Scoreboard bench for ddr_rd_port_arbiter; covers the watchdog when DDR_RD_ARB_WATCHDOG_EN is defined.
module tb_ddr_rd_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 30;
    localparam int DW = 256;
`ifdef DDR_RD_ARB_WATCHDOG_EN
    localparam int TMO = 256;
`else
    localparam int TMO = 4096;
`endif

    logic              ddr_clk_i = 1'b0;
    logic              ddr_rst_n_i = 1'b1;
    logic [NR-1:0]     s_req_i = '0;
    logic [NR*8-1:0]   s_len_i = '0;
    logic [NR*AW-1:0]  s_addr_i = '0;
    logic [NR-1:0]     s_data_valid_o;
    logic [DW-1:0]     s_data_o;
    logic [NR-1:0]     s_finish_o;
    logic              m_req_o;
    logic [7:0]        m_len_o;
    logic [AW-1:0]     m_addr_o;
    logic              m_data_valid_i = 1'b0;
    logic [DW-1:0]     m_data_i = '0;
    logic              m_finish_i = 1'b0;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              len_err_o;
`ifdef DDR_RD_ARB_WATCHDOG_EN
    logic              wdog_err_o;
`endif

    always #5 ddr_clk_i = ~ddr_clk_i;

    ddr_rd_port_arbiter #(
        .NUM_REQ       (NR),
        .ADDR_WIDTH    (AW),
        .MEM_DATA_BITS (DW),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .ddr_clk_i      (ddr_clk_i),
        .ddr_rst_n_i    (ddr_rst_n_i),
        .s_req_i        (s_req_i),
        .s_len_i        (s_len_i),
        .s_addr_i       (s_addr_i),
        .s_data_valid_o (s_data_valid_o),
        .s_data_o       (s_data_o),
        .s_finish_o     (s_finish_o),
        .m_req_o        (m_req_o),
        .m_len_o        (m_len_o),
        .m_addr_o       (m_addr_o),
        .m_data_valid_i (m_data_valid_i),
        .m_data_i       (m_data_i),
        .m_finish_i     (m_finish_i),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .len_err_o      (len_err_o)
`ifdef DDR_RD_ARB_WATCHDOG_EN
        ,
        .wdog_err_o     (wdog_err_o)
`endif
    );

    typedef struct {
        logic [NR-1:0] mask;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [NR-1:0] mask;
        int            cyc;
    } fin_t;

    beat_t beat_q[$];
    fin_t  fin_q[$];
    beat_t mon_b;
    fin_t  mon_f;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    rr_exp = 0;

    always @(posedge ddr_clk_i) cyc <= cyc + 1;

    // Scoreboard: every forwarded beat and finish pulse must match the next expectation.
    always @(negedge ddr_clk_i) begin
        if (s_data_valid_o !== '0) begin
            total++;
            if (beat_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got valid=%b cyc=%0d, required no beat", s_data_valid_o, cyc);
            end else begin
                mon_b = beat_q.pop_front();
                if (s_data_valid_o !== mon_b.mask || s_data_o !== mon_b.data || cyc != mon_b.cyc) begin
                    bad++;
                    $display("FAIL beat: got valid=%b cyc=%0d data=%h, required valid=%b cyc=%0d data=%h",
                             s_data_valid_o, cyc, s_data_o, mon_b.mask, mon_b.cyc, mon_b.data);
                end
            end
        end
        if (s_finish_o !== '0) begin
            total++;
            if (fin_q.size() == 0) begin
                bad++;
                $display("FAIL finish_unexpected: got finish=%b cyc=%0d, required no finish", s_finish_o, cyc);
            end else begin
                mon_f = fin_q.pop_front();
                if (s_finish_o !== mon_f.mask || cyc != mon_f.cyc) begin
                    bad++;
                    $display("FAIL finish: got finish=%b cyc=%0d, required finish=%b cyc=%0d",
                             s_finish_o, cyc, mon_f.mask, mon_f.cyc);
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge ddr_clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input int len, input logic [AW-1:0] addr);
        s_len_i[p*8 +: 8]    = 8'(len);
        s_addr_i[p*AW +: AW] = addr;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge ddr_clk_i);
            if (m_req_o === 1'b1) seen = 1'b1;
        end
    endtask

    // Serve one burst as the DDR engine; the granted port and issued length/address are checked.
    task automatic run_burst(input int port, input int len, input logic [AW-1:0] addr, input int nbeats,
                             input bit fin_last, input logic [NR-1:0] drop_first,
                             input logic [NR-1:0] drop_fin, output int seen_cyc);
        bit            seen;
        logic [NR-1:0] mk;
        mk = '0;
        mk[port] = 1'b1;
        wait_req(seen);
        seen_cyc = cyc;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL grant_timeout: port %0d m_req_o=%b after 64 cycles, required 1", port, m_req_o);
            return;
        end
        total++;
        if (grant_o !== mk || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL grant: got grant=%b busy=%b, required grant=%b busy=1", grant_o, busy_o, mk);
        end
        total++;
        if (m_len_o !== 8'(len) || m_addr_o !== addr) begin
            bad++;
            $display("FAIL issue: got len=%0d addr=%h, required len=%0d addr=%h", m_len_o, m_addr_o, len, addr);
        end
        for (int b = 0; b < nbeats; b++) begin
            tick();
            m_data_valid_i = 1'b1;
            m_data_i       = rand_beat();
            beat_q.push_back('{mask: mk, data: m_data_i, cyc: cyc + 1});
            if (b == 0) s_req_i &= ~drop_first;
            if (b == nbeats - 1 && fin_last) begin
                m_finish_i = 1'b1;
                fin_q.push_back('{mask: mk, cyc: cyc + 2});
                s_req_i &= ~drop_fin;
            end
        end
        tick();
        m_data_valid_i = 1'b0;
        m_finish_i     = 1'b0;
        total++;
        if (m_req_o !== 1'b0) begin
            bad++;
            $display("FAIL req_drop: got m_req_o=%b after first beat, required 0", m_req_o);
        end
        if (!fin_last) begin
            m_finish_i = 1'b1;
            fin_q.push_back('{mask: mk, cyc: cyc + 2});
            s_req_i &= ~drop_fin;
            tick();
            m_finish_i = 1'b0;
        end
        rr_exp = (port + 1) % NR;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge ddr_clk_i);
            if (beat_q.size() == 0 && fin_q.size() == 0 && busy_o === 1'b0) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain: got beats_left=%0d finishes_left=%0d busy=%b, required 0 0 0",
                     beat_q.size(), fin_q.size(), busy_o);
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (grant_o !== '0 || m_req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got grant=%b req=%b busy=%b, required 0 0 0", grant_o, m_req_o, busy_o);
        end
        total++;
        if (s_data_valid_o !== '0 || s_finish_o !== '0 || s_data_o !== '0) begin
            bad++;
            $display("FAIL reset_s: got valid=%b finish=%b data=%h, required 0", s_data_valid_o, s_finish_o, s_data_o);
        end
        total++;
        if (m_len_o !== '0 || m_addr_o !== '0 || len_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_m: got len=%0d addr=%h len_err=%b, required 0 0 0", m_len_o, m_addr_o, len_err_o);
        end
        @(negedge ddr_clk_i);
        ddr_rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int c0;
        int sc;
        set_port(1, 128, 30'h0800000);
        tick();
        s_req_i = 4'b0010;
        c0 = cyc;
        run_burst(1, 128, 30'h0800000, 128, 1'b0, 4'b0010, 4'b0000, sc);
        total++;
        if (sc != c0 + 1) begin
            bad++;
            $display("FAIL single_latency: got m_req_o after %0d cycles, required 1", sc - c0);
        end
        wait_drain();
        total++;
        if (len_err_o !== 1'b0 || grant_o !== '0) begin
            bad++;
            $display("FAIL single_end: got len_err=%b grant=%b, required 0 0", len_err_o, grant_o);
        end
    endtask

    task automatic test_round_robin();
        int start;
        int p;
        int sc;
        for (int i = 0; i < NR; i++) set_port(i, 4, AW'(32'h100 * (i + 1)));
        start = rr_exp;
        tick();
        s_req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            p = (start + i) % NR;
            run_burst(p, 4, AW'(32'h100 * (p + 1)), 4, 1'b0, 4'b0000, (i == 4) ? 4'b1111 : 4'b0000, sc);
        end
        wait_drain();
    endtask

    task automatic test_drop_first();
        int sc;
        set_port(1, 2, 30'h10);
        set_port(2, 4, 30'h2000);
        set_port(3, 4, 30'h3000);
        tick();
        s_req_i = 4'b0010;
        run_burst(1, 2, 30'h10, 2, 1'b1, 4'b0010, 4'b0000, sc);
        wait_drain();
        s_req_i = 4'b1100;
        run_burst(2, 4, 30'h2000, 4, 1'b0, 4'b0100, 4'b0000, sc);
        run_burst(3, 4, 30'h3000, 4, 1'b0, 4'b1000, 4'b0000, sc);
        wait_drain();
        repeat (3) @(negedge ddr_clk_i);
        total++;
        if (grant_o !== '0 || m_req_o !== 1'b0) begin
            bad++;
            $display("FAIL drop_regrant: got grant=%b req=%b, required 0 0", grant_o, m_req_o);
        end
    endtask

    task automatic test_finish_coincident();
        int sc;
        set_port(0, 4, 30'h4000);
        tick();
        s_req_i = 4'b0001;
        run_burst(0, 4, 30'h4000, 4, 1'b1, 4'b0001, 4'b0000, sc);
        wait_drain();
        total++;
        if (len_err_o !== 1'b0) begin
            bad++;
            $display("FAIL len_ok: got len_err=%b, required 0", len_err_o);
        end
        s_req_i = 4'b0001;
        run_burst(0, 4, 30'h4000, 3, 1'b0, 4'b0001, 4'b0000, sc);
        wait_drain();
        total++;
        if (len_err_o !== 1'b1) begin
            bad++;
            $display("FAIL len_short: got len_err=%b, required 1", len_err_o);
        end
        repeat (5) tick();
        total++;
        if (len_err_o !== 1'b1) begin
            bad++;
            $display("FAIL len_sticky: got len_err=%b, required 1", len_err_o);
        end
    endtask

    task automatic test_reset_mid();
        bit            seen;
        logic [NR-1:0] mk;
        int            sc;
        mk = 4'b0010;
        set_port(1, 100, 30'h5000);
        tick();
        s_req_i = 4'b0010;
        wait_req(seen);
        total++;
        if (!seen || grant_o !== mk) begin
            bad++;
            $display("FAIL mid_grant: got req=%b grant=%b, required 1 %b", m_req_o, grant_o, mk);
        end
        for (int b = 0; b < 50; b++) begin
            tick();
            m_data_valid_i = 1'b1;
            m_data_i       = rand_beat();
            beat_q.push_back('{mask: mk, data: m_data_i, cyc: cyc + 1});
            if (b == 0) s_req_i = 4'b0000;
        end
        tick();
        m_data_valid_i = 1'b0;
        @(negedge ddr_clk_i);
        #2;
        ddr_rst_n_i = 1'b0;
        #1;
        total++;
        if (grant_o !== '0 || m_req_o !== 1'b0 || busy_o !== 1'b0 || len_err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got grant=%b req=%b busy=%b len_err=%b, required 0 0 0 0",
                     grant_o, m_req_o, busy_o, len_err_o);
        end
        total++;
        if (s_data_valid_o !== '0 || m_len_o !== '0 || m_addr_o !== '0) begin
            bad++;
            $display("FAIL mid_reset_data: got valid=%b len=%0d addr=%h, required 0", s_data_valid_o, m_len_o, m_addr_o);
        end
        repeat (2) @(negedge ddr_clk_i);
        set_port(0, 2, 30'h6000);
        set_port(3, 2, 30'h7000);
        s_req_i = 4'b1001;
        ddr_rst_n_i = 1'b1;
        run_burst(0, 2, 30'h6000, 2, 1'b1, 4'b0001, 4'b0000, sc);
        run_burst(3, 2, 30'h7000, 2, 1'b1, 4'b1000, 4'b0000, sc);
        wait_drain();
    endtask

    task automatic test_stray();
        tick();
        m_data_valid_i = 1'b1;
        m_finish_i     = 1'b1;
        m_data_i       = rand_beat();
        tick();
        m_data_valid_i = 1'b0;
        m_finish_i     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ddr_clk_i);
            total++;
            if (s_data_valid_o !== '0 || s_finish_o !== '0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL stray: got valid=%b finish=%b busy=%b, required 0 0 0", s_data_valid_o, s_finish_o, busy_o);
            end
        end
        total++;
        if (len_err_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_len: got len_err=%b, required 0", len_err_o);
        end
    endtask

`ifdef DDR_RD_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit seen;
        int sc;
        set_port(2, 8, 30'h8000);
        tick();
        s_req_i = 4'b0100;
        wait_req(seen);
        s_req_i = 4'b0000;
        fin_q.push_back('{mask: 4'b0100, cyc: cyc + TMO + 1});
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wdog_grant: got m_req_o=%b, required 1", m_req_o);
        end
        repeat (TMO + 4) @(negedge ddr_clk_i);
        total++;
        if (wdog_err_o !== 1'b1 || len_err_o !== 1'b1 || fin_q.size() != 0) begin
            bad++;
            $display("FAIL wdog: got wdog_err=%b len_err=%b pending=%0d, required 1 1 0",
                     wdog_err_o, len_err_o, fin_q.size());
        end
        set_port(1, 2, 30'h9000);
        tick();
        s_req_i = 4'b0010;
        run_burst(1, 2, 30'h9000, 2, 1'b1, 4'b0010, 4'b0000, sc);
        wait_drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion by 200us, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        #1 ddr_rst_n_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop_first();
        test_finish_coincident();
        test_reset_mid();
        test_stray();
`ifdef DDR_RD_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        repeat (4) @(negedge ddr_clk_i);
        total++;
        if (beat_q.size() != 0 || fin_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got beats=%0d finishes=%0d outstanding, required 0 0", beat_q.size(), fin_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
